// File: rtl/mmio_csr_responder.sv
// mmio_csr_responder: MMIO CSR responder for host-initiated read/write traffic.
// Decodes flattened CCI-P c0 MMIO requests and maintains the AFU CSRs. These are
// DFH, the AFU ID halves, scratch, the host buffer address and control/status.
// Read responses are queued in a show-ahead FIFO and drained through a
// valid/ready response port.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   mmio_req_*            one request per cycle when mmio_req_valid
//                         (read/write, dword address, 4B/8B, tid, write data)
//   cpu_busy              busy status from the cpu block
//   mmio_rsp_valid/ready  response handshake; mmio_rsp_tid/data is the FIFO head
//   buffer_addr(_valid)   host buffer address and "fully written" flag
//   cpu_start             one-cycle start pulse
module mmio_csr_responder #(
  parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_0000,
  parameter logic [63:0] AFU_ID_L  = 64'h0,
  parameter logic [63:0] AFU_ID_H  = 64'h0,
  parameter int unsigned RSP_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mmio_req_valid,
  input  logic        mmio_req_is_read,
  input  logic [15:0] mmio_req_addr,
  input  logic        mmio_req_len8,
  input  logic [8:0]  mmio_req_tid,
  input  logic [63:0] mmio_req_data,
  input  logic        cpu_busy,
  output logic        mmio_rsp_valid,
  input  logic        mmio_rsp_ready,
  output logic [8:0]  mmio_rsp_tid,
  output logic [63:0] mmio_rsp_data,
  output logic [63:0] buffer_addr,
  output logic        buffer_addr_valid,
  output logic        cpu_start
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned TID_W  = 9;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [ADDR_W-1:0] ADDR_DFH      = 16'h0000;
  localparam logic [ADDR_W-1:0] ADDR_AFU_ID_L = 16'h0002;
  localparam logic [ADDR_W-1:0] ADDR_AFU_ID_H = 16'h0004;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH  = 16'h0010;
  localparam logic [ADDR_W-1:0] ADDR_BUF_ADDR = 16'h0012;
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 16'h0014;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 16'h0016;

  // CSR state
  logic [DATA_W-1:0] scratch_q, scratch_d;
  logic [DATA_W-1:0] buf_addr_q, buf_addr_d;
  logic              buf_addr_valid_q, buf_addr_valid_d;
  logic              overflow_q, overflow_d;
  logic              cpu_start_q, cpu_start_d;

  // Response FIFO state
  logic [TID_W-1:0]  tid_mem_q  [RSP_DEPTH];
  logic [DATA_W-1:0] data_mem_q [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Request decode
  logic [ADDR_W-1:0] base_addr_c;
  logic              rd_req_c, wr_req_c;
  logic              scratch_we_c, buf_we_c, ctrl_we_c;
  logic [DATA_W-1:0] reg_rd_c, rd_data_c;
  logic              full_c, push_c, pop_c, drop_c;

  // 8B registers live at even dword addresses; odd addresses select the upper half.
  assign base_addr_c = {mmio_req_addr[ADDR_W-1:1], 1'b0};
  assign rd_req_c    = mmio_req_valid & mmio_req_is_read;
  assign wr_req_c    = mmio_req_valid & ~mmio_req_is_read;

  assign scratch_we_c = wr_req_c && (base_addr_c == ADDR_SCRATCH);
  assign buf_we_c     = wr_req_c && (base_addr_c == ADDR_BUF_ADDR);
  // CTRL bits sit in the low dword, so a 4B write to the odd half has no effect.
  assign ctrl_we_c    = wr_req_c && (base_addr_c == ADDR_CTRL) &&
                        (mmio_req_len8 || !mmio_req_addr[0]);

  // Merge write data into a 64b register according to access size and half.
  function automatic logic [DATA_W-1:0] merge_write(
    input logic [DATA_W-1:0] cur,
    input logic [DATA_W-1:0] wdata,
    input logic              len8,
    input logic              odd
  );
    logic [DATA_W-1:0] res;
    res = cur;
    if (len8) begin
      res = wdata;
    end else if (odd) begin
      res[63:32] = wdata[31:0];
    end else begin
      res[31:0] = wdata[31:0];
    end
    return res;
  endfunction

  // Read mux: full register, then narrowed to the addressed dword for 4B reads.
  always_comb begin
    reg_rd_c = '0;
    unique case (base_addr_c)
      ADDR_DFH:      reg_rd_c = DFH_VALUE;
      ADDR_AFU_ID_L: reg_rd_c = AFU_ID_L;
      ADDR_AFU_ID_H: reg_rd_c = AFU_ID_H;
      ADDR_SCRATCH:  reg_rd_c = scratch_q;
      ADDR_BUF_ADDR: reg_rd_c = buf_addr_q;
      ADDR_STATUS:   reg_rd_c = {62'b0, overflow_q, cpu_busy};
      default:       reg_rd_c = '0;
    endcase
    if (mmio_req_len8) begin
      rd_data_c = reg_rd_c;
    end else if (mmio_req_addr[0]) begin
      rd_data_c = {32'b0, reg_rd_c[63:32]};
    end else begin
      rd_data_c = {32'b0, reg_rd_c[31:0]};
    end
  end

  // FIFO control: a full FIFO still accepts a push when the head pops this cycle.
  assign full_c = (count_q == CNT_W'(RSP_DEPTH));
  assign pop_c  = mmio_rsp_valid & mmio_rsp_ready;
  assign push_c = rd_req_c & (~full_c | pop_c);
  assign drop_c = rd_req_c & full_c & ~pop_c;

  // Next-state logic
  always_comb begin
    scratch_d        = scratch_q;
    buf_addr_d       = buf_addr_q;
    buf_addr_valid_d = buf_addr_valid_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    cpu_start_d      = ctrl_we_c & mmio_req_data[0];
    // A new drop wins over a simultaneous clear.
    overflow_d       = (overflow_q & ~(ctrl_we_c & mmio_req_data[1])) | drop_c;

    if (scratch_we_c) begin
      scratch_d = merge_write(scratch_q, mmio_req_data, mmio_req_len8, mmio_req_addr[0]);
    end
    if (buf_we_c) begin
      buf_addr_d       = merge_write(buf_addr_q, mmio_req_data, mmio_req_len8, mmio_req_addr[0]);
      // Valid only once the high dword (or the whole value) has been written.
      buf_addr_valid_d = mmio_req_len8 | mmio_req_addr[0];
    end

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q        <= '0;
      buf_addr_q       <= '0;
      buf_addr_valid_q <= 1'b0;
      overflow_q       <= 1'b0;
      cpu_start_q      <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      scratch_q        <= scratch_d;
      buf_addr_q       <= buf_addr_d;
      buf_addr_valid_q <= buf_addr_valid_d;
      overflow_q       <= overflow_d;
      cpu_start_q      <= cpu_start_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
    end
  end

  // FIFO storage; contents are don't-care while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      tid_mem_q[wr_ptr_q]  <= mmio_req_tid;
      data_mem_q[wr_ptr_q] <= rd_data_c;
    end
  end

  // Show-ahead outputs; valid derives from the reset count so it drops with rst_n.
  assign mmio_rsp_valid    = (count_q != '0);
  assign mmio_rsp_tid      = tid_mem_q[rd_ptr_q];
  assign mmio_rsp_data     = data_mem_q[rd_ptr_q];
  assign buffer_addr       = buf_addr_q;
  assign buffer_addr_valid = buf_addr_valid_q;
  assign cpu_start         = cpu_start_q;

endmodule

// File: tb/tb_mmio_csr_responder.sv
// tb_mmio_csr_responder: directed and randomized bench for mmio_csr_responder.
// A behavioural model (register variables plus a response queue) predicts every
// cycle's outputs; directed steps also check literal expected values.
module tb_mmio_csr_responder;

  localparam logic [63:0] DFH   = 64'h1000_0000_0000_0000;
  localparam logic [63:0] IDL   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] IDH   = 64'hFEDC_BA98_7654_3210;
  localparam int          DEPTH = 8;

  typedef struct packed {
    logic [8:0]  tid;
    logic [63:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_is_read, req_len8, busy, rsp_ready;
  logic [15:0] req_addr;
  logic [8:0]  req_tid;
  logic [63:0] req_data;
  logic        rsp_valid, buf_valid, start;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data, buf_addr;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [63:0] m_scratch, m_buf;
  logic        m_bvalid, m_ovf, m_start;
  rsp_t        m_q[$];

  mmio_csr_responder #(
    .DFH_VALUE(DFH), .AFU_ID_L(IDL), .AFU_ID_H(IDH), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mmio_req_valid(req_valid), .mmio_req_is_read(req_is_read),
    .mmio_req_addr(req_addr), .mmio_req_len8(req_len8),
    .mmio_req_tid(req_tid), .mmio_req_data(req_data),
    .cpu_busy(busy),
    .mmio_rsp_valid(rsp_valid), .mmio_rsp_ready(rsp_ready),
    .mmio_rsp_tid(rsp_tid), .mmio_rsp_data(rsp_data),
    .buffer_addr(buf_addr), .buffer_addr_valid(buf_valid),
    .cpu_start(start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_scratch = '0; m_buf = '0; m_bvalid = 0; m_ovf = 0; m_start = 0;
    m_q.delete();
  endtask

  // Value a read of this address/size should return, from the register map.
  function automatic logic [63:0] m_read(input logic [15:0] addr, input logic len8);
    logic [63:0] r;
    int base;
    base = int'(addr) & ~1;
    case (base)
      'h00:    r = DFH;
      'h02:    r = IDL;
      'h04:    r = IDH;
      'h10:    r = m_scratch;
      'h12:    r = m_buf;
      'h16:    r = {62'b0, m_ovf, busy};
      default: r = 64'h0;
    endcase
    if (len8) return r;
    return addr[0] ? {32'b0, r[63:32]} : {32'b0, r[31:0]};
  endfunction

  function automatic logic [63:0] m_write(input logic [63:0] cur);
    logic [63:0] r;
    r = cur;
    if (req_len8) r = req_data;
    else if (req_addr[0]) r[63:32] = req_data[31:0];
    else r[31:0] = req_data[31:0];
    return r;
  endfunction

  // One clock: advance the model on the current inputs, then check all outputs.
  task automatic step();
    bit   pop, full, rd, wr, ctrl, drop;
    int   base;
    rsp_t e;
    base = int'(req_addr) & ~1;
    rd   = req_valid && req_is_read;
    wr   = req_valid && !req_is_read;
    pop  = rsp_ready && (m_q.size() != 0);
    full = (m_q.size() == DEPTH);
    drop = 0;
    e.tid  = req_tid;
    e.data = m_read(req_addr, req_len8);
    if (pop) void'(m_q.pop_front());
    if (rd) begin
      if (!full || pop) m_q.push_back(e);
      else drop = 1;
    end
    ctrl    = wr && base == 'h14 && (req_len8 || !req_addr[0]);
    m_start = ctrl && req_data[0];
    if (wr && base == 'h10) m_scratch = m_write(m_scratch);
    if (wr && base == 'h12) begin
      m_buf    = m_write(m_buf);
      m_bvalid = req_len8 || req_addr[0];
    end
    m_ovf = (m_ovf && !(ctrl && req_data[1])) || drop;
    @(posedge clk); #1;
    check("rsp_valid", 64'(rsp_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("rsp_tid", 64'(rsp_tid), 64'(m_q[0].tid));
      check("rsp_data", rsp_data, m_q[0].data);
    end
    check("buffer_addr", buf_addr, m_buf);
    check("buffer_addr_valid", 64'(buf_valid), 64'(m_bvalid));
    check("cpu_start", 64'(start), 64'(m_start));
  endtask

  task automatic req(input logic rd, input logic [15:0] addr, input logic len8,
                     input logic [8:0] tid, input logic [63:0] data);
    req_valid = 1; req_is_read = rd; req_addr = addr; req_len8 = len8;
    req_tid = tid; req_data = data;
    step();
    req_valid = 0;
  endtask

  initial begin
    rst_n = 0; req_valid = 0; req_is_read = 0; req_addr = '0; req_len8 = 0;
    req_tid = '0; req_data = '0; busy = 0; rsp_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_buf_addr", buf_addr, 64'h0);
    check("reset_buf_valid", 64'(buf_valid), 64'(0));
    check("reset_cpu_start", 64'(start), 64'(0));
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // 1: DFH read
    req(1, 16'h0000, 1, 9'd5, '0);
    check("t1_valid", 64'(rsp_valid), 64'(1));
    check("t1_tid", 64'(rsp_tid), 64'd5);
    check("t1_data", rsp_data, DFH);

    // 2: scratch write then 4B read of the upper dword
    req(0, 16'h0010, 1, '0, 64'hDEAD_BEEF_0123_4567);
    req(1, 16'h0011, 0, 9'd7, '0);
    check("t2_data", rsp_data, 64'h0000_0000_DEAD_BEEF);

    // 3: buffer address in two halves
    req(0, 16'h0012, 0, '0, 64'h1000);
    check("t3_valid_lo", 64'(buf_valid), 64'(0));
    req(0, 16'h0013, 0, '0, 64'h1);
    check("t3_valid_hi", 64'(buf_valid), 64'(1));
    check("t3_addr", buf_addr, 64'h1_0000_1000);

    // 4: cpu_start pulse and STATUS busy bit
    req(0, 16'h0014, 0, '0, 64'h1);
    check("t4_start_hi", 64'(start), 64'(1));
    step();
    check("t4_start_lo", 64'(start), 64'(0));
    busy = 1;
    req(1, 16'h0016, 1, 9'd9, '0);
    check("t4_status", rsp_data, 64'h1);
    busy = 0;

    // 5: overflow with ready held low, then in-order drain and clear
    step();
    rsp_ready = 0;
    for (int i = 0; i < 9; i++) req(1, 16'h0000, 1, 9'(i), '0);
    rsp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check("t5_order", 64'(rsp_tid), 64'(i));
      step();
    end
    check("t5_empty", 64'(rsp_valid), 64'(0));
    req(1, 16'h0016, 1, 9'd20, '0);
    check("t5_ovf_set", rsp_data, 64'h2);
    req(0, 16'h0014, 0, '0, 64'h2);
    req(1, 16'h0016, 1, 9'd21, '0);
    check("t5_ovf_clr", rsp_data, 64'h0);
    step();

    // 6: async reset with pending responses
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) req(1, 16'h0002, 1, 9'(30 + i), '0);
    #2 rst_n = 0;
    #1;
    check("t6_async_valid", 64'(rsp_valid), 64'(0));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    rsp_ready = 1;
    step();
    check("t6_buf_valid", 64'(buf_valid), 64'(0));

    // Randomized traffic against the model, with periodic back-pressure bursts
    for (int i = 0; i < 800; i++) begin
      req_valid   = ($urandom_range(0, 3) != 0);
      req_is_read = $urandom_range(0, 1) == 1;
      req_addr    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 'h17));
      req_len8    = $urandom_range(0, 1) == 1;
      req_tid     = 9'($urandom);
      req_data    = {$urandom, $urandom};
      busy        = $urandom_range(0, 1) == 1;
      rsp_ready   = ((i % 64) < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
